// File: rtl/srio_type9_dmasplit_if.sv
// rtl/srio_type9_dmasplit_if.sv - AXI-Stream beat bundle for the type 9 DMA splitter
// Signals: tvalid/tready handshake, 64-bit tdata, tlast, 32-bit tuser.
// master drives tvalid/tdata/tlast/tuser and samples tready; slave is the mirror.
interface srio_type9_dmasplit_if;
    logic        tvalid;
    logic        tready;
    logic [63:0] tdata;
    logic        tlast;
    logic [31:0] tuser;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/srio_type9_dmasplit.sv
// rtl/srio_type9_dmasplit.sv - splits a HELLO-headed DMA PDU into SRIO Ftype 9 segments
// Ports:
//   AXIS_ACLK     clock, rising edge
//   AXIS_ARESETN  asynchronous active-low reset
//   s_axis        slave stream: header beat, then payload, tlast on final payload beat
//   m_axis        master stream: per segment a rewritten header beat, then payload
//   DROP_PULSE    one-cycle pulse when a header-only PDU is discarded
module srio_type9_dmasplit #(
    parameter int BUF_AW = 5
) (
    input  logic                          AXIS_ACLK,
    input  logic                          AXIS_ARESETN,
    srio_type9_dmasplit_if.slave          s_axis,
    srio_type9_dmasplit_if.master         m_axis,
    output logic                          DROP_PULSE
);
    localparam int DEPTH = 1 << BUF_AW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_HDR,
        ST_DRAIN
    } state_t;

    state_t state;
    state_t state_nx;

    logic [63:0]     seg_buf [DEPTH];
    logic [61:8]     hdr_mid;       // header bits that pass through unchanged
    logic [31:0]     tuser_reg;
    logic            first;
    logic            last;
    logic [BUF_AW-1:0] wr_cnt;
    logic [BUF_AW-1:0] rd_cnt;
    logic [BUF_AW:0]   seg_beats;
    logic            rdy_en;        // holds tready low until the first clock after reset
    logic            drop_q;

    logic            s_ready;
    logic            m_valid;
    logic            m_last;
    logic [63:0]     m_data;
    logic            s_hs;
    logic            m_hs;
    logic            rd_last;
    logic [7:0]      size_field;

    assign s_ready = rdy_en && (state == ST_IDLE || state == ST_FILL);
    assign m_valid = (state == ST_HDR) || (state == ST_DRAIN);
    assign s_hs    = s_ready && s_axis.tvalid;
    assign m_hs    = m_valid && m_axis.tready;
    assign rd_last = ({1'b0, rd_cnt} == (seg_beats - (BUF_AW+1)'(1)));

    // Size field is segment bytes minus one, truncated to 8 bits (256 bytes -> 0xFF).
    assign size_field = 8'({seg_beats, 3'b000} - (BUF_AW+4)'(1));

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = m_data;
    assign m_axis.tlast  = m_last;
    assign m_axis.tuser  = tuser_reg;
    assign DROP_PULSE    = drop_q;

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        m_last   = 1'b0;
        m_data   = 64'd0;
        case (state)
            ST_IDLE: begin
                if (s_hs && !s_axis.tlast) begin
                    state_nx = ST_FILL;
                end
            end
            ST_FILL: begin
                // Close the segment on PDU end or when the buffer is full.
                if (s_hs && (s_axis.tlast || (&wr_cnt))) begin
                    state_nx = ST_HDR;
                end
            end
            ST_HDR: begin
                m_data = {first, last, hdr_mid, size_field};
                if (m_axis.tready) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                m_data = seg_buf[rd_cnt];
                m_last = rd_last;
                if (m_axis.tready && rd_last) begin
                    state_nx = last ? ST_IDLE : ST_FILL;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            rdy_en    <= 1'b0;
            drop_q    <= 1'b0;
            hdr_mid   <= '0;
            tuser_reg <= '0;
            first     <= 1'b0;
            last      <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            seg_beats <= '0;
        end else begin
            rdy_en <= 1'b1;
            drop_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_hs) begin
                        hdr_mid   <= s_axis.tdata[61:8];
                        tuser_reg <= s_axis.tuser;
                        first     <= 1'b1;
                        last      <= 1'b0;
                        wr_cnt    <= '0;
                        drop_q    <= s_axis.tlast;
                    end
                end
                ST_FILL: begin
                    if (s_hs) begin
                        wr_cnt    <= wr_cnt + BUF_AW'(1);
                        seg_beats <= {1'b0, wr_cnt} + (BUF_AW+1)'(1);
                        // A full segment ends the PDU only if tlast lands on that beat.
                        last      <= s_axis.tlast;
                    end
                end
                ST_HDR: begin
                    if (m_hs) begin
                        rd_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (m_hs) begin
                        rd_cnt <= rd_cnt + BUF_AW'(1);
                        if (rd_last && !last) begin
                            first  <= 1'b0;
                            wr_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Segment storage has no reset; contents are only read after being written.
    always_ff @(posedge AXIS_ACLK) begin
        if (state == ST_FILL && s_hs) begin
            seg_buf[wr_cnt] <= s_axis.tdata;
        end
    end
endmodule

// File: doc/srio_type9_dmasplit.md
# srio_type9_dmasplit

Segments a DMA-side AXI-Stream PDU (one SRIO HELLO header beat followed by payload, TLAST on the final payload beat) into SRIO Ftype 9 streaming packets of at most 2^BUF_AW payload beats each. Each output packet carries its own copy of the PDU header, with the start and end bits and the size field rewritten per segment. The block sits on the transmit path between the DMA engine and the SRIO core, and performs the inverse of the type 9 receive-side combiner.

## Interface

- BUF_AW, 5, log2 of the maximum payload beats per segment (5 gives 32 beats, 256 bytes).
- AXIS_ACLK  in  1  single clock; all logic is on the rising edge.
- AXIS_ARESETN  in  1  reset, asynchronous and active-low.
- S_AXIS_TVALID  in  1  input beat valid.
- S_AXIS_TREADY  out  1  input ready.
- S_AXIS_TDATA  in  64  beat 0 is the HELLO header; later beats are payload.
- S_AXIS_TLAST  in  1  last beat of the PDU.
- S_AXIS_TUSER  in  32  sampled on the header beat only.
- M_AXIS_TVALID  out  1  output beat valid.
- M_AXIS_TREADY  in  1  output ready.
- M_AXIS_TDATA  out  64  segment header beat, then payload beats.
- M_AXIS_TLAST  out  1  last payload beat of each segment.
- M_AXIS_TUSER  out  32  captured PDU TUSER, driven on every beat.
- DROP_PULSE  out  1  one-cycle pulse when a header-only PDU is discarded.

## Operation

- Segment buffer: 2^BUF_AW x 64 bits, holding one segment at a time. Filling and draining do not overlap.
- States and transitions:
  - IDLE: S_AXIS_TREADY=1. On a header handshake, capture TDATA into hdr_reg and TUSER into tuser_reg, and set first=1.
    - If TLAST is also set: pulse DROP_PULSE and stay in IDLE.
    - Otherwise go to FILL.
  - FILL: S_AXIS_TREADY=1. Each handshake writes the buffer at wr_cnt and increments wr_cnt. Go to HDR when either condition holds:
    - TLAST: set last=1.
    - wr_cnt reaches 2^BUF_AW-1 on the handshake: last=TLAST.
  - HDR: M_AXIS_TVALID=1, M_AXIS_TLAST=0.
    - M_AXIS_TDATA = hdr_reg with [63]=first, [62]=last, [7:0]=(seg_beats*8)-1 mod 256. All other bits come from hdr_reg.
    - On handshake, go to DRAIN and set rd_cnt=0.
  - DRAIN: M_AXIS_TDATA = buf[rd_cnt]; M_AXIS_TLAST=(rd_cnt==seg_beats-1).
    - On the TLAST handshake: if last=1 go to IDLE; otherwise clear first, reset wr_cnt and go to FILL.
- seg_beats ranges from 1 to 2^BUF_AW and is held in a BUF_AW+1-bit register.
- A segment that reaches 2^BUF_AW beats gets its end bit only if TLAST arrived on exactly that beat. A subsequent empty segment is never produced.
- Input header bits [63:62] are ignored and always overwritten.
- S_AXIS_TREADY=0 in HDR and DRAIN. M_AXIS_TVALID=0 in IDLE and FILL.

## Timing

- Reset values, applied immediately on assertion: M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, M_AXIS_TUSER=0, DROP_PULSE=0, S_AXIS_TREADY=0.
  - S_AXIS_TREADY goes to 1 on the first clock after deassertion, when the state is IDLE.
- Segment-closing beat accepted at edge N: the header is valid in the cycle following edge N.
- No bubbles between the header and payload, or between payload beats, while M_AXIS_TREADY=1. A segment of k beats occupies exactly k+1 output cycles.
- After the final DRAIN handshake at edge N, S_AXIS_TREADY=1 in the following cycle.
- Once TVALID is asserted, TDATA, TLAST and TUSER stay stable until the handshake, per AXI-Stream.
- Reset mid-PDU: the partial segment and all counters are discarded. The next header beat after reset starts a new PDU with first=1.
- DROP_PULSE is high for exactly the one cycle following the edge that accepted the header-only beat.

## Test plan

- Header 0x0000_1234_0000_00FF with TUSER=0xA5, 10 payload beats, BUF_AW=5.
  - Expect one packet: header 0xC000_1234_0000_004F with TUSER 0xA5, then 10 beats in order, TLAST on beat 10.
- 70-beat PDU.
  - Expect three packets of 32, 32 and 6 beats.
  - Header bits [63:62] are 10, 00, 01; [7:0] are 0xFF, 0xFF, 0x2F.
- Exactly 32 beats: one packet, [63:62]=11. Exactly 64 beats: two packets, 10 then 01. No empty third packet.
- Random M_AXIS_TREADY (50%) and random S_AXIS_TVALID over 200 PDUs of 1-100 beats.
  - Payload order and count preserved; TVALID never drops without a handshake; TLAST count equals packet count.
- Header beat with TLAST=1.
  - Nothing emitted; DROP_PULSE high for 1 cycle; the next 5-beat PDU is emitted normally with [63:62]=11.
- Assert AXIS_ARESETN low during DRAIN of the 2nd segment of a 50-beat PDU.
  - Outputs go to zero immediately; after release, a fresh 3-beat PDU is emitted as a single packet with [63:62]=11.
